rotary_decoder: RTL

- Front-end for the board's rotary shaft encoder.
- Takes the raw, asynchronous, bouncing quadrature contacts (rot_a, rot_b) and synchronises and debounces them.
- Decodes detent steps into a one-cycle rot_event strobe plus a held rot_dir level.
- Feeds the LED ripple stage directly downstream, which edge-detects rot_event and samples rot_dir on that edge. Also keeps a wrapping detent counter for display/debug.

---
 rtl/rotary_decoder_pkg.sv | 12 +
 rtl/rotary_decoder_contact_debounce.sv | 56 +++++
 rtl/rotary_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rotary_decoder_pkg.sv
// Shared encodings for the rotary encoder front-end.
package rotary_decoder_pkg;

  // Controller states: PRIME masks events while the input pipeline settles.
  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // rot_dir encoding.
  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/rotary_decoder_contact_debounce.sv
// One encoder contact: metastability synchroniser followed by a
// persistence filter. The filtered value only follows the synced value
// once they have disagreed for DEBOUNCE_CYCLES consecutive samples.
module contact_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // Plain shift chain; nothing may sit between these flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // Mismatch counter: cleared by any agreement, commits on the last
  // required mismatching sample, never counts past that point.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_s == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
      filt_d = sync_s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rotary_decoder.sv
// Rotary shaft encoder front-end: debounced quadrature decode into a
// one-cycle rot_event strobe, a held rot_dir level and a wrapping counter.
//
// Output protocol: rot_event is a single-cycle strobe with no back-pressure.
// rot_dir and detent_count update on the same edge that raises rot_event,
// so rot_dir is valid whenever rot_event is high and holds until the next.
module rotary_decoder
  import rotary_decoder_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rot_a,
  input  logic                 rot_b,
  output logic                 rot_event,
  output logic                 rot_dir,
  output logic [CNT_WIDTH-1:0] detent_count,
  output logic                 primed
);

  // Long enough for a contact closed at reset to reach q1 and q1 delayed.
  localparam int PRIME_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 2;
  localparam int PW           = $clog2(PRIME_CYCLES + 1);

  logic                 fa, fb;
  logic                 q1_q, q1_d;
  logic                 q2_q, q2_d;
  logic                 q1_prev_q;     // q1 delayed one cycle, for rise detect
  logic [0:0]           state_q, state_d;
  logic [PW-1:0]        prime_cnt_q, prime_cnt_d;
  logic                 primed_q, primed_d;
  logic                 event_q, event_d;
  logic                 dir_q, dir_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 q1_rise;

  contact_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw_i (rot_a),
    .filt_o(fa)
  );

  contact_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw_i (rot_b),
    .filt_o(fb)
  );

  // Quadrature flops: q1 marks the detent crossing, q2 remembers which
  // contact moved first and therefore the direction.
  always_comb begin
    q1_d = q1_q;
    q2_d = q2_q;
    case ({fb, fa})
      2'b00:   q1_d = 1'b0;
      2'b01:   q2_d = 1'b0;
      2'b10:   q2_d = 1'b1;
      default: q1_d = 1'b1;
    endcase
  end

  assign q1_rise = q1_q & ~q1_prev_q;

  // Controller: count out priming, then turn each q1 rise into one event.
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    primed_d    = primed_q;
    event_d     = 1'b0;
    dir_d       = dir_q;
    count_d     = count_q;
    case (state_q)
      ST_PRIME: begin
        if (prime_cnt_q == PW'(PRIME_CYCLES - 1)) begin
          state_d     = ST_RUN;
          primed_d    = 1'b1;
          prime_cnt_d = '0;
        end else begin
          prime_cnt_d = prime_cnt_q + PW'(1);
        end
      end
      default: begin
        if (q1_rise) begin
          event_d = 1'b1;
          dir_d   = q2_q ? DIR_CW : DIR_CCW;
          count_d = q2_q ? count_q + CNT_WIDTH'(1) : count_q - CNT_WIDTH'(1);
        end
      end
    endcase
  end

  // All decode and controller state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1_q        <= 1'b0;
      q2_q        <= 1'b0;
      q1_prev_q   <= 1'b0;
      state_q     <= ST_PRIME;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
      event_q     <= 1'b0;
      dir_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      q1_prev_q   <= q1_q;
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      event_q     <= event_d;
      dir_q       <= dir_d;
      count_q     <= count_d;
    end
  end

  assign rot_event    = event_q;
  assign rot_dir      = dir_q;
  assign detent_count = count_q;
  assign primed       = primed_q;

endmodule
